// File: rtl/trig_coinc_engine.sv
// Coincidence trigger: masked inputs -> per-channel windows -> multiplicity -> fire FSM + record FIFO.
// Fire decision 4 edges after capture; records are held until rec_ready pops them, drops flag rec_overflow.
module trig_coinc_engine #(
  parameter int NCH    = 64,
  parameter int NTRIG  = 8,
  parameter int TW     = 6,
  parameter int TSW    = 56,
  parameter int FDEPTH = 8,
  parameter int CW     = $clog2(NCH + 1)
) (
  input  logic                  clk_adc,
  input  logic                  nrst,
  input  logic [NCH-1:0]        chan_in,
  input  logic [NCH-1:0]        chan_mask,
  input  logic [TW-1:0]         coinc_time,
  input  logic [NTRIG*CW-1:0]   thresh,
  input  logic [NTRIG-1:0]      trig_enable,
  input  logic [31:0]           prescale,
  input  logic [31:0]           randnum,
  input  logic                  run_gate,
  input  logic                  busy_in,
  input  logic [7:0]            out_len,
  input  logic [7:0]            dead_time,
  input  logic                  ts_clear,
  output logic                  trig_out,
  output logic                  rec_valid,
  input  logic                  rec_ready,
  output logic [NTRIG-1:0]      rec_mask,
  output logic [TSW-1:0]        rec_time,
  output logic                  rec_overflow
);
  localparam int GS = 8;
  localparam int NG = (NCH + GS - 1) / GS;
  localparam int PW = $clog2(GS + 1);
  localparam int AW = $clog2(FDEPTH);
  localparam int RW = NTRIG + TSW;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_FIRE = 2'd1;
  localparam logic [1:0] S_DEAD = 2'd2;
  localparam logic [AW:0]  PTR_ONE = 1;
  localparam logic [TW-1:0] WIN_ONE = 1;
  localparam logic [TSW-1:0] TS_ONE = 1;

  logic [NCH-1:0]   in_q;
  logic [TW-1:0]    win_q [NCH];
  logic [NG*GS-1:0] act;
  logic [PW-1:0]    part_q [NG];
  logic [PW-1:0]    part_d [NG];
  logic [CW-1:0]    count_q, count_d;
  logic             pass_q;
  logic [NTRIG-1:0] sat;
  logic             fire;
  logic [1:0]       state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [TSW-1:0]   ts_q;
  logic [RW-1:0]    mem_q [FDEPTH];
  logic [AW:0]      wp_q, rp_q;
  logic             empty, full, pop, push_ok, ovf_q;

  // Groups padded to a whole multiple of GS so the partial sums need no range guards.
  always_comb begin
    act = '0;
    for (int c = 0; c < NCH; c++) act[c] = (win_q[c] != '0);
    for (int g = 0; g < NG; g++) begin
      part_d[g] = '0;
      for (int i = 0; i < GS; i++) part_d[g] = part_d[g] + PW'(act[g*GS+i]);
    end
    count_d = '0;
    for (int g = 0; g < NG; g++) count_d = count_d + CW'(part_q[g]);
  end

  always_comb begin
    for (int k = 0; k < NTRIG; k++)
      sat[k] = trig_enable[k] && (thresh[k*CW +: CW] != '0) && (count_q >= thresh[k*CW +: CW]);
  end

  assign fire = (state_q == S_IDLE) && (|sat) && run_gate && !busy_in && pass_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: if (fire) begin
        state_d = S_FIRE;
        cnt_d   = (out_len == 8'd0) ? 8'd0 : out_len - 8'd1;
      end
      S_FIRE: if (cnt_q == 8'd0) begin
        if (dead_time == 8'd0) state_d = S_IDLE;
        else begin
          state_d = S_DEAD;
          cnt_d   = dead_time - 8'd1;
        end
      end else cnt_d = cnt_q - 8'd1;
      S_DEAD: if (cnt_q == 8'd0) state_d = S_IDLE;
              else cnt_d = cnt_q - 8'd1;
      default: state_d = S_IDLE;
    endcase
  end

  assign empty   = (wp_q == rp_q);
  assign full    = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
  assign pop     = rec_ready && !empty;
  assign push_ok = fire && (!full || pop);

  always_ff @(posedge clk_adc) begin
    if (!nrst) begin
      in_q    <= '0;
      for (int c = 0; c < NCH; c++) win_q[c] <= '0;
      for (int g = 0; g < NG; g++) part_q[g] <= '0;
      count_q <= '0;
      pass_q  <= 1'b0;
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      ts_q    <= '0;
      wp_q    <= '0;
      rp_q    <= '0;
      ovf_q   <= 1'b0;
    end else begin
      in_q <= ~chan_in & chan_mask;
      // A hit always reloads, so an open window is never stretched past coinc_time.
      for (int c = 0; c < NCH; c++) begin
        if (in_q[c]) win_q[c] <= coinc_time;
        else if (win_q[c] != '0) win_q[c] <= win_q[c] - WIN_ONE;
      end
      for (int g = 0; g < NG; g++) part_q[g] <= part_d[g];
      count_q <= count_d;
      pass_q  <= (randnum <= prescale);
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ts_q    <= ts_clear ? '0 : ts_q + TS_ONE;
      if (pop)     rp_q <= rp_q + PTR_ONE;
      if (push_ok) wp_q <= wp_q + PTR_ONE;
      if (ts_clear)              ovf_q <= 1'b0;
      else if (fire && !push_ok) ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge clk_adc) begin
    if (nrst && push_ok) mem_q[wp_q[AW-1:0]] <= {sat, ts_q};
  end

  assign trig_out     = (state_q == S_FIRE);
  assign rec_valid    = !empty;
  assign {rec_mask, rec_time} = empty ? '0 : mem_q[rp_q[AW-1:0]];
  assign rec_overflow = ovf_q;
endmodule

// File: tb/tb_trig_coinc_engine.sv
// Bench for trig_coinc_engine: directed scenarios plus random traffic against an event-level model.
module tb_trig_coinc_engine;
  localparam int NCH = 64, NTRIG = 8, TW = 6, TSW = 56, FDEPTH = 8, CW = 7;
  localparam int MAXE = 8192;

  logic                clk_adc = 1'b0;
  logic                nrst = 1'b0;
  logic [NCH-1:0]      chan_in = '1;
  logic [NCH-1:0]      chan_mask = '1;
  logic [TW-1:0]       coinc_time = 6'd4;
  logic [NTRIG*CW-1:0] thresh = '0;
  logic [NTRIG-1:0]    trig_enable = '0;
  logic [31:0]         prescale = 32'hFFFFFFFF;
  logic [31:0]         randnum = 32'd0;
  logic                run_gate = 1'b1;
  logic                busy_in = 1'b0;
  logic [7:0]          out_len = 8'd2;
  logic [7:0]          dead_time = 8'd2;
  logic                ts_clear = 1'b0;
  logic                rec_ready = 1'b0;
  logic                trig_out, rec_valid, rec_overflow;
  logic [NTRIG-1:0]    rec_mask;
  logic [TSW-1:0]      rec_time;

  trig_coinc_engine #(.NCH(NCH), .NTRIG(NTRIG), .TW(TW), .TSW(TSW), .FDEPTH(FDEPTH)) dut (
    .clk_adc(clk_adc), .nrst(nrst), .chan_in(chan_in), .chan_mask(chan_mask),
    .coinc_time(coinc_time), .thresh(thresh), .trig_enable(trig_enable),
    .prescale(prescale), .randnum(randnum), .run_gate(run_gate), .busy_in(busy_in),
    .out_len(out_len), .dead_time(dead_time), .ts_clear(ts_clear), .trig_out(trig_out),
    .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_mask(rec_mask), .rec_time(rec_time),
    .rec_overflow(rec_overflow)
  );

  always #5 clk_adc = ~clk_adc;

  int n_chk = 0, n_pass = 0;
  int ecount = 0;

  // Input history, indexed by the edge that sampled it.
  logic [NCH-1:0] hit_h [MAXE];
  int             ct_h  [MAXE];
  bit             pass_h[MAXE];

  typedef struct { logic [7:0] m; longint t; } rec_t;
  rec_t mq[$];
  int   last_rst = -1, last_zero = 0, pulse_end = 0, next_allowed = 0, leave_edge = -1;
  bit   m_ovf = 1'b0;

  int n_rise, last_rise, min_gap, min_w, max_w, hi_len;
  bit prev_trig = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Event-level reference: a channel counts as active while the age of its most
  // recent hit is within the window length that hit loaded.
  task automatic model_step(input int e);
    int m, cnt, th, len;
    logic [7:0] s;
    bit ps, fire, drop;
    if (!nrst) begin
      mq.delete();
      m_ovf = 1'b0; last_zero = e; last_rst = e;
      pulse_end = e; next_allowed = e + 1; leave_edge = -1;
      return;
    end
    if (e == leave_edge) begin
      next_allowed = e + int'(dead_time) + 1;
      leave_edge = -1;
    end
    m = e - 3; cnt = 0;
    for (int c = 0; c < NCH; c++)
      for (int n = m - 1; n > last_rst && n >= m - 64 && n >= 0; n--)
        if (hit_h[n][c]) begin
          if (m - n <= ct_h[n+1]) cnt++;
          break;
        end
    s = '0;
    for (int k = 0; k < NTRIG; k++) begin
      th = int'(thresh[k*CW +: CW]);
      s[k] = trig_enable[k] && th != 0 && cnt >= th;
    end
    ps = (e - 1 > last_rst) && pass_h[e-1];
    fire = (e >= next_allowed) && (s != 0) && run_gate && !busy_in && ps;
    if (rec_ready && mq.size() > 0) void'(mq.pop_front());
    drop = 1'b0;
    if (fire) begin
      len = (out_len == 0) ? 1 : int'(out_len);
      pulse_end = e + len; leave_edge = e + len; next_allowed = 1 << 30;
      if (mq.size() < FDEPTH) mq.push_back('{s, longint'(e - 1 - last_zero)});
      else drop = 1'b1;
    end
    if (ts_clear) begin m_ovf = 1'b0; last_zero = e; end
    else if (drop) m_ovf = 1'b1;
  endtask

  task automatic step();
    if (ecount >= MAXE) begin
      $display("FAIL edge_budget: got %0d edges limit %0d", ecount, MAXE);
      $fatal(1);
    end
    hit_h[ecount]  = ~chan_in & chan_mask;
    ct_h[ecount]   = int'(coinc_time);
    pass_h[ecount] = (randnum <= prescale);
    @(posedge clk_adc);
    model_step(ecount);
    #1;
    check("trig_out", {63'd0, trig_out}, {63'd0, ecount < pulse_end});
    check("rec_valid", {63'd0, rec_valid}, {63'd0, mq.size() > 0});
    check("rec_overflow", {63'd0, rec_overflow}, {63'd0, m_ovf});
    if (mq.size() > 0) begin
      check("rec_mask", {56'd0, rec_mask}, {56'd0, mq[0].m});
      check("rec_time", {8'd0, rec_time}, mq[0].t);
    end
    if (trig_out === 1'b1) begin
      if (!prev_trig) begin
        n_rise++;
        if (last_rise >= 0 && ecount - last_rise < min_gap) min_gap = ecount - last_rise;
        last_rise = ecount; hi_len = 0;
      end
      hi_len++;
    end else if (prev_trig) begin
      if (hi_len < min_w) min_w = hi_len;
      if (hi_len > max_w) max_w = hi_len;
    end
    prev_trig = (trig_out === 1'b1);
    ecount++;
  endtask

  task automatic clr_obs();
    n_rise = 0; last_rise = -1; min_gap = 1000000; min_w = 1000; max_w = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic hit_vec(input logic [NCH-1:0] v);
    chan_in = ~v; step(); chan_in = '1;
  endtask

  task automatic do_reset();
    nrst = 1'b0; chan_in = '1; rec_ready = 1'b0; ts_clear = 1'b0;
    idle(2); nrst = 1'b1; idle(2);
  endtask

  task automatic base_cfg(input int ct, input int ol, input int dt);
    chan_mask = '1; thresh = '0; trig_enable = 8'h01; thresh[0 +: CW] = 7'd1;
    coinc_time = TW'(ct); out_len = 8'(ol); dead_time = 8'(dt);
    prescale = 32'hFFFFFFFF; randnum = 32'd0; run_gate = 1'b1; busy_in = 1'b0;
  endtask

  initial begin
    longint tq[$];
    bit inc;
    logic [63:0] w;

    // Reset held with every input asserted: nothing may fire or be recorded.
    base_cfg(4, 2, 2); clr_obs();
    nrst = 1'b0; chan_in = '0; idle(6);
    check("t1_no_fire_in_reset", 64'(n_rise), 64'd0);
    check("t1_no_rec_in_reset", {63'd0, rec_valid}, 64'd0);
    chan_in = '1; nrst = 1'b1; idle(3);

    // Majority of three: 4-tick spacing overlaps in a 10-tick window, 12-tick does not.
    base_cfg(10, 2, 2); thresh[0 +: CW] = 7'd3; do_reset(); clr_obs();
    w = 64'd1; hit_vec(w); idle(3);
    w = 64'd1 << 5; hit_vec(w); idle(3);
    w = 64'd1 << 9; hit_vec(w); idle(30);
    check("t2_one_fire", 64'(n_rise), 64'd1);
    check("t2_mask", {56'd0, rec_mask}, 64'h01);
    rec_ready = 1'b1; step(); rec_ready = 1'b0;
    clr_obs();
    w = 64'd1; hit_vec(w); idle(11);
    w = 64'd1 << 5; hit_vec(w); idle(11);
    w = 64'd1 << 9; hit_vec(w); idle(30);
    check("t2_spaced_no_fire", 64'(n_rise), 64'd0);

    // Pulse width and deadtime under a steady hit stream.
    base_cfg(2, 16, 20); do_reset(); clr_obs();
    for (int i = 0; i < 24; i++) begin hit_vec(64'd1); idle(4); end
    idle(40);
    check("t3_min_width", 64'(min_w), 64'd16);
    check("t3_max_width", 64'(max_w), 64'd16);
    check("t3_gap_ge_36", {63'd0, min_gap >= 36}, 64'd1);
    check("t3_several_fires", {63'd0, n_rise >= 3}, 64'd1);

    // Vetoes and prescale.
    base_cfg(3, 2, 2); do_reset();
    clr_obs(); busy_in = 1'b1; hit_vec(64'd1); idle(10); busy_in = 1'b0;
    check("t4_busy_veto", 64'(n_rise), 64'd0);
    clr_obs(); run_gate = 1'b0; hit_vec(64'd1); idle(10); run_gate = 1'b1;
    check("t4_run_gate", 64'(n_rise), 64'd0);
    clr_obs(); prescale = 32'd0; randnum = 32'd1; idle(2); hit_vec(64'd1); idle(10);
    check("t4_prescale_block", 64'(n_rise), 64'd0);
    clr_obs(); randnum = 32'd0; idle(2); hit_vec(64'd1); idle(10);
    check("t4_prescale_pass", 64'(n_rise), 64'd1);

    // FIFO fill past depth, then drain.
    base_cfg(1, 1, 0); do_reset(); clr_obs();
    for (int i = 0; i < 9; i++) begin hit_vec(64'd1 << i); idle(5); end
    check("t5_nine_fires", 64'(n_rise), 64'd9);
    check("t5_overflow", {63'd0, rec_overflow}, 64'd1);
    tq.delete(); rec_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (rec_valid === 1'b1) tq.push_back(longint'(rec_time));
      step();
    end
    rec_ready = 1'b0;
    check("t5_popped", 64'(tq.size()), 64'd8);
    inc = 1'b1;
    for (int i = 1; i < tq.size(); i++) if (tq[i] <= tq[i-1]) inc = 1'b0;
    check("t5_ts_increasing", {63'd0, inc}, 64'd1);

    // Two triggers at different thresholds; timestamp clear mid-run.
    base_cfg(4, 2, 2); trig_enable = 8'h03; thresh[CW +: CW] = 7'd2; do_reset();
    w = (64'd1 << 3) | (64'd1 << 7); hit_vec(w); idle(10);
    check("t6_mask", {56'd0, rec_mask}, 64'h03);
    rec_ready = 1'b1; step(); rec_ready = 1'b0;
    idle(50);
    ts_clear = 1'b1; step(); ts_clear = 1'b0;
    hit_vec(w); idle(10);
    check("t6_valid", {63'd0, rec_valid}, 64'd1);
    check("t6_ts_small", {63'd0, rec_time < 20}, 64'd1);

    // Random traffic against the model.
    for (int b = 0; b < 12; b++) begin
      chan_mask   = {$urandom, $urandom} | {$urandom, $urandom};
      coinc_time  = TW'($urandom_range(0, 12));
      out_len     = 8'($urandom_range(0, 6));
      dead_time   = 8'($urandom_range(0, 6));
      trig_enable = 8'($urandom);
      for (int k = 0; k < NTRIG; k++) thresh[k*CW +: CW] = 7'($urandom_range(0, 4));
      prescale    = ($urandom_range(0, 1) == 0) ? 32'hFFFFFFFF : $urandom;
      for (int i = 0; i < 200; i++) begin
        chan_in   = ~({$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom});
        randnum   = $urandom;
        busy_in   = ($urandom_range(0, 9) == 0);
        run_gate  = ($urandom_range(0, 19) != 0);
        rec_ready = ($urandom_range(0, 3) == 0);
        ts_clear  = ($urandom_range(0, 99) == 0);
        nrst      = ($urandom_range(0, 299) != 0);
        step();
      end
    end
    nrst = 1'b1; chan_in = '1; busy_in = 1'b0; ts_clear = 1'b0; idle(5);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
